mul_256b_seq: RTL and testbench

MUL_256B_SEQ -- requirements
Module: mul_256b_seq

---
 rtl/mul_256b_seq_pkg.sv | 27 ++
 rtl/mul_64b_sim_model.sv | 13 +
 rtl/mul_256b_seq.sv | 134 +++++++++++++
 tb/tb_mul_256b_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_256b_seq_pkg.sv
// Shared arithmetic constants and types for the sequential 256x256 multiplier.
package mul_256b_seq_pkg;

  localparam int LIMB_W  = 64;                 // limb width
  localparam int N_LIMB  = 4;                  // limbs per operand
  localparam int LIMB_SH = 6;                  // log2(LIMB_W)
  localparam int OP_W    = LIMB_W * N_LIMB;    // operand width
  localparam int PROD_W  = 2 * LIMB_W;         // limb product width
  localparam int RES_W   = 2 * OP_W;           // full product width
  localparam int K_W     = 4;                  // step counter width, N_LIMB*N_LIMB steps
  localparam int SHIFT_W = 3;                  // limb shift index, 0..6

  localparam logic [K_W-1:0] K_LAST = 4'd15;   // final issue step

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Limb shift of the partial product issued at step k: a-limb index plus b-limb index.
  function automatic logic [SHIFT_W-1:0] shift_of(input logic [K_W-1:0] k);
    return {1'b0, k[3:2]} + {1'b0, k[1:0]};
  endfunction

endpackage

// File: rtl/mul_64b_sim_model.sv
// Behavioural 64x64 -> 128-bit unsigned multiplier; replaced by vendor IP in synthesis.
module mul_64b_sim_model
  import mul_256b_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] A,
  input  logic [LIMB_W-1:0] B,
  output logic [PROD_W-1:0] P
);

  // Zero-extend both operands so the product is formed at full 128-bit width.
  assign P = {{LIMB_W{1'b0}}, A} * {{LIMB_W{1'b0}}, B};

endmodule

// File: rtl/mul_256b_seq.sv
// Sequential 256x256 -> 512-bit unsigned multiplier. One 64x64 multiplier is
// time-shared over the 16 schoolbook limb products; each product is registered
// with its limb shift and added into a 512-bit accumulator on the next cycle.
module mul_256b_seq
  import mul_256b_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] p
);

  state_t state_reg, state_next;

  logic              accept;
  logic              issue;
  logic [OP_W-1:0]   a_reg, b_reg;
  logic [K_W-1:0]    k_reg;
  logic [LIMB_W-1:0] a_limb [N_LIMB];
  logic [LIMB_W-1:0] b_limb [N_LIMB];
  logic [LIMB_W-1:0] mul_a, mul_b;
  logic [PROD_W-1:0] mul_p;
  logic [PROD_W-1:0] prod_reg;
  logic [SHIFT_W-1:0] shift_reg;
  logic              prod_valid_reg;
  logic [RES_W-1:0]  acc_reg;
  logic [RES_W-1:0]  acc_term;

  assign accept = in_valid & in_ready;

  // Split the latched operands into limbs for the select muxes.
  genvar gi;
  generate
    for (gi = 0; gi < N_LIMB; gi++) begin : g_limb
      assign a_limb[gi] = a_reg[gi*LIMB_W +: LIMB_W];
      assign b_limb[gi] = b_reg[gi*LIMB_W +: LIMB_W];
    end
  endgenerate

  // Upper counter bits walk the a-limbs, lower bits the b-limbs.
  assign mul_a = a_limb[k_reg[3:2]];
  assign mul_b = b_limb[k_reg[1:0]];

  mul_64b_sim_model u_mul (
    .A (mul_a),
    .B (mul_b),
    .P (mul_p)
  );

  // Partial product placed at its limb position; the shift is a whole number of limbs.
  assign acc_term = {{(RES_W-PROD_W){1'b0}}, prod_reg} << {shift_reg, {LIMB_SH{1'b0}}};

  // The result port is the accumulator itself, so it keeps the last result while idle.
  assign p = acc_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        issue = 1'b1;
        if (k_reg == K_LAST) state_next = FLUSH;
      end
      FLUSH: begin
        // Only the last product is still in flight; it lands in the accumulator this cycle.
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, loaded only on the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  // Step counter; wraps back to zero after the final issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      k_reg <= '0;
    else if (accept) k_reg <= '0;
    else if (issue)  k_reg <= k_reg + K_W'(1);
  end

  // Product register with its limb shift; valid only for cycles that issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg       <= '0;
      shift_reg      <= '0;
      prod_valid_reg <= 1'b0;
    end else begin
      prod_valid_reg <= issue;
      if (issue) begin
        prod_reg  <= mul_p;
        shift_reg <= shift_of(k_reg);
      end
    end
  end

  // Accumulator: cleared on acceptance, then adds one shifted partial product per valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              acc_reg <= '0;
    else if (accept)         acc_reg <= '0;
    else if (prod_valid_reg) acc_reg <= acc_reg + acc_term;
  end

endmodule

// File: tb/tb_mul_256b_seq.sv
// Testbench for mul_256b_seq: directed vector table, hold and reset sequences,
// and randomized back-to-back traffic checked against plain wide multiplication.
module tb_mul_256b_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] a;
  logic [255:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] p;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t_acc  = 0;

  mul_256b_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [255:0] va;
    logic [255:0] vb;
    logic [511:0] vp;
  } vec_t;

  // Reference: the product computed directly as a 512-bit multiplication.
  function automatic logic [511:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] wx, wy;
    wx = {256'd0, x};
    wy = {256'd0, y};
    return wx * wy;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present operands while idle; acceptance happens at the next rising edge.
  task automatic issue(input logic [255:0] ia, input logic [255:0] ib);
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
    chk_int("ready_before_accept", int'(in_ready), 1);
    step();
    t_acc    = cyc;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid with a bounded cycle budget. Latency counts the acceptance
  // cycle as cycle 1, so 16 MUL cycles + FLUSH put DONE in cycle 18.
  task automatic wait_result(input bit junk, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = rnd256();
        b        = rnd256();
      end else begin
        in_valid = 1'b0;
      end
      chk_int("busy_in_ready", int'(in_ready), 0);
      step();
      n++;
    end
    in_valid = 1'b0;
    chk_int("result_timeout", int'(out_valid), 1);
    lat = cyc - t_acc + 1;
  endtask

  // Output handshake, then confirm the result is not presented twice.
  task automatic take_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_int("no_duplicate_out_valid", int'(out_valid), 0);
    chk_int("idle_after_handshake", int'(in_ready), 1);
  endtask

  vec_t         vecs [5];
  logic [255:0] ones256, pow192, ra, rb, ra2, rb2;
  logic [511:0] exp_p, tmp;
  int           lat;
  int           stall;
  int           mode;

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    rst_n     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("reset_in_ready", int'(in_ready), 1);
    chk_int("reset_out_valid", int'(out_valid), 0);
    chk_wide("reset_p", p, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors; expected products are written from the arithmetic identities.
    ones256 = '1;
    pow192  = 256'd1 << 192;
    tmp     = 512'd1 << 257;
    vecs[0] = '{256'd1, 256'd1, 512'd1};
    vecs[1] = '{ones256, ones256, (512'd0 - tmp) + 512'd1};
    vecs[2] = '{pow192, pow192, 512'd1 << 384};
    vecs[3] = '{256'd0, rnd256(), 512'd0};
    vecs[4] = '{256'hFFFF_FFFF_FFFF_FFFF, 256'd2, 512'h1_FFFF_FFFF_FFFF_FFFE};

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].va, vecs[i].vb);
      wait_result(1'b0, lat);
      chk_int($sformatf("vec%0d_latency", i), lat, 18);
      chk_wide($sformatf("vec%0d_p", i), p, vecs[i].vp);
      $display("vector %0d: latency=%0d p[127:0]=%h", i, lat, p[127:0]);
      take_result();
    end

    // Hold: requests during MUL and DONE are ignored; result held while out_ready=0.
    ra    = rnd256();
    rb    = rnd256();
    ra2   = rnd256();
    rb2   = rnd256();
    exp_p = ref_mul(ra, rb);
    issue(ra, rb);
    wait_result(1'b1, lat);
    chk_int("hold_latency", lat, 18);
    chk_wide("hold_p", p, exp_p);
    a        = ra2;
    b        = rb2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_int("hold_out_valid", int'(out_valid), 1);
      chk_int("hold_in_ready", int'(in_ready), 0);
      chk_wide("hold_p_stable", p, exp_p);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_int("hold_not_accepted_at_handshake", int'(in_ready), 1);
    chk_int("hold_out_valid_cleared", int'(out_valid), 0);
    $display("hold first: p[127:0]=%h", exp_p[127:0]);
    step();
    t_acc    = cyc;
    in_valid = 1'b0;
    chk_int("hold_second_accepted", int'(in_ready), 0);
    wait_result(1'b0, lat);
    chk_int("hold_second_latency", lat, 18);
    chk_wide("hold_second_p", p, ref_mul(ra2, rb2));
    $display("hold second: latency=%0d p[127:0]=%h", lat, p[127:0]);
    take_result();

    // Reset mid-MUL at step k=7, then a fresh request straight after release.
    ra = rnd256() | 256'd1;
    rb = rnd256() | 256'd1;
    issue(ra, rb);
    repeat (7) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_int("midrst_out_valid", int'(out_valid), 0);
    chk_int("midrst_in_ready", int'(in_ready), 1);
    chk_wide("midrst_p", p, '0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(256'd3, 256'd5);
    wait_result(1'b0, lat);
    chk_int("post_reset_latency", lat, 18);
    chk_wide("post_reset_p", p, 512'd15);
    $display("post-reset: latency=%0d p=%0d", lat, p[31:0]);
    take_result();

    // Random back-to-back traffic with junk requests while busy and output stalls.
    for (int it = 0; it < 1000; it++) begin
      ra   = rnd256();
      rb   = rnd256();
      mode = $urandom_range(0, 9);
      if (mode == 0) ra = '1;
      if (mode == 1) rb = '0;
      if (mode == 2) begin ra = '1; rb = '1; end
      exp_p = ref_mul(ra, rb);
      issue(ra, rb);
      wait_result(1'b1, lat);
      chk_int("rand_latency", lat, 18);
      chk_wide("rand_p", p, exp_p);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'($urandom_range(0, 1));
        step();
        chk_int("rand_stall_out_valid", int'(out_valid), 1);
        chk_wide("rand_stall_p", p, exp_p);
      end
      in_valid = 1'b0;
      take_result();
      $display("txn %0d: latency=%0d stall=%0d p[63:0]=%h", it, lat, stall, p[63:0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
